// File: rtl/pll_phase_ctrl_if.sv
// Phase-request channel between the config logic and the PLL phase controller.
// Latency: none, wires only.
// Backpressure: req_valid is held by the master until req_ready is seen high.
interface pll_phase_ctrl_if #(
    parameter int STEP_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_ch;
    logic [STEP_W-1:0] req_phase;
    logic              req_err;

    modport master (
        output req_valid, req_ch, req_phase,
        input  req_ready, req_err
    );

    modport slave (
        input  req_valid, req_ch, req_phase,
        output req_ready, req_err
    );
endinterface

// File: rtl/pll_phase_ctrl.sv
// Runtime phase tuner for a PLL: steps PSSEL/PSDIR/PSPULSE the short way round, tracks phases, supervises lock.
// Latency: 1 setup cycle, then PULSE_HI+PULSE_GAP per step, then 2 lock-qualified cycles before the next request.
// Backpressure: req_ready is high only in IDLE with lock qualified, and drops for 1 cycle after a no-op request.
module pll_phase_ctrl #(
    parameter int                         NUM_CH       = 4,
    parameter int                         STEP_W       = 6,
    parameter int                         STEPS        = 64,
    parameter logic [NUM_CH*STEP_W-1:0]   INIT_PHASE   = '0,
    parameter int                         PULSE_HI     = 4,
    parameter int                         PULSE_GAP    = 4,
    parameter int                         RESET_CYCLES = 16,
    parameter int                         LOCK_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              resetn,
    pll_phase_ctrl_if.slave   req,
    input  logic [2:0]        rd_ch,
    output logic [STEP_W-1:0] rd_phase,
    output logic              busy,
    output logic              locked,
    output logic [7:0]        relock_cnt,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic [2:0]        pll_pssel,
    output logic              pll_psdir,
    output logic              pll_pspulse
);

    typedef enum logic [2:0] {
        ST_RST_PLL, ST_WAIT_LOCK, ST_IDLE, ST_SETUP, ST_PULSE, ST_GAP, ST_SETTLE
    } state_t;

    localparam logic [STEP_W:0]   STEPS_W = (STEP_W+1)'(STEPS);
    localparam logic [STEP_W:0]   HALF_W  = (STEP_W+1)'(STEPS / 2);
    localparam logic [STEP_W-1:0] LAST_PH = STEP_W'(STEPS - 1);

    function automatic logic [STEP_W-1:0] init_entry(input int k);
        logic [NUM_CH*STEP_W-1:0] sh;
        sh = INIT_PHASE >> (k * STEP_W);
        return (k < NUM_CH) ? sh[STEP_W-1:0] : '0;
    endfunction

    state_t            state_q, state_nxt;
    logic [31:0]       cnt_q;
    logic              lock_meta, lock_s, lk_seen_q;
    logic [STEP_W-1:0] tbl_q [8];
    logic [2:0]        ch_q;
    logic              dir_q;
    logic [STEP_W:0]   steps_q;
    logic              hold_q, err_q, locked_q;
    logic [7:0]        relock_q;

    logic              rdy;
    logic              accept, cnt_clr, step_done, go_rst, go_idle, lock_lost;
    logic              req_bad, wait_done, timeout;
    logic [STEP_W-1:0] cur, step_cur, step_nxt;
    logic [STEP_W:0]   diff_raw, diff, nsteps, up;
    logic              adv;

    // Shortest-rotation decision, all in STEP_W+1 bits so STEPS need not be a power of two.
    always_comb begin
        cur      = tbl_q[req.req_ch];
        req_bad  = ({1'b0, req.req_ch} >= 4'(NUM_CH)) || ({1'b0, req.req_phase} >= STEPS_W);
        diff_raw = {1'b0, req.req_phase} + STEPS_W - {1'b0, cur};
        diff     = (diff_raw >= STEPS_W) ? diff_raw - STEPS_W : diff_raw;
        adv      = (diff <= HALF_W);
        nsteps   = adv ? diff : STEPS_W - diff;
        step_cur = tbl_q[ch_q];
        up       = {1'b0, step_cur} + 1'b1;
        if (dir_q) begin
            step_nxt = (step_cur == '0) ? LAST_PH : step_cur - 1'b1;
        end else begin
            step_nxt = (up == STEPS_W) ? '0 : up[STEP_W-1:0];
        end
    end

    assign rdy       = (state_q == ST_IDLE) && locked_q && !hold_q;
    assign wait_done = lock_s && lk_seen_q;
    assign timeout   = (cnt_q == 32'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= ST_RST_PLL;
        else         state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        cnt_clr   = 1'b0;
        step_done = 1'b0;
        go_rst    = 1'b0;
        go_idle   = 1'b0;
        lock_lost = 1'b0;
        unique case (state_q)
            ST_RST_PLL: begin
                if (cnt_q == 32'(RESET_CYCLES - 1)) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_clr   = 1'b1;
                end
            end
            ST_WAIT_LOCK, ST_SETTLE: begin
                if (wait_done) begin
                    state_nxt = ST_IDLE;
                    go_idle   = 1'b1;
                end else if (timeout) begin
                    state_nxt = ST_RST_PLL;
                    go_rst    = 1'b1;
                    cnt_clr   = 1'b1;
                end
            end
            ST_IDLE: begin
                // A completed handshake wins over a same-cycle lock drop; SETTLE re-checks lock.
                if (req.req_valid && rdy) begin
                    accept = 1'b1;
                    if (!req_bad && diff != '0) begin
                        state_nxt = ST_SETUP;
                        cnt_clr   = 1'b1;
                    end
                end else if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_clr   = 1'b1;
                    lock_lost = 1'b1;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_PULSE;
                cnt_clr   = 1'b1;
            end
            ST_PULSE: begin
                if (cnt_q == 32'(PULSE_HI - 1)) begin
                    state_nxt = ST_GAP;
                    cnt_clr   = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 32'(PULSE_GAP - 1)) begin
                    step_done = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = (steps_q == (STEP_W+1)'(1)) ? ST_SETTLE : ST_PULSE;
                end
            end
            default: state_nxt = ST_RST_PLL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            lk_seen_q <= 1'b0;
            cnt_q     <= '0;
            ch_q      <= '0;
            dir_q     <= 1'b0;
            steps_q   <= '0;
            hold_q    <= 1'b0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
            relock_q  <= '0;
            for (int k = 0; k < 8; k++) tbl_q[k] <= init_entry(k);
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
            lk_seen_q <= (state_q == ST_WAIT_LOCK || state_q == ST_SETTLE) && lock_s;
            cnt_q     <= cnt_clr ? '0 : cnt_q + 32'd1;
            err_q     <= accept && req_bad;
            hold_q    <= accept && !req_bad && (diff == '0);
            if (accept && !req_bad && diff != '0) begin
                ch_q    <= req.req_ch;
                dir_q   <= !adv;
                steps_q <= nsteps;
            end
            if (step_done) begin
                tbl_q[ch_q] <= step_nxt;
                steps_q     <= steps_q - 1'b1;
            end
            if (go_idle)              locked_q <= 1'b1;
            if (lock_lost || go_rst)  locked_q <= 1'b0;
            // A forced PLL reset returns every output to its static phase.
            if (go_rst) begin
                if (relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
                for (int k = 0; k < 8; k++) tbl_q[k] <= init_entry(k);
            end
        end
    end

    assign req.req_ready = rdy;
    assign req.req_err   = err_q;
    assign rd_phase      = tbl_q[rd_ch];
    assign busy          = (state_q != ST_IDLE);
    assign locked        = locked_q;
    assign relock_cnt    = relock_q;
    assign pll_reset     = (state_q == ST_RST_PLL);
    assign pll_pssel     = ch_q;
    assign pll_psdir     = dir_q;
    assign pll_pspulse   = (state_q == ST_PULSE);

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl: a step-schedule model predicts every post-accept cycle.
// Latency: n/a.
// Backpressure: requests are issued only once the previous predicted schedule has fully drained.
module tb_pll_phase_ctrl;

    localparam int NUM_CH  = 4;
    localparam int STEP_W  = 6;
    localparam int STEPS   = 64;
    localparam int HI      = 4;
    localparam int GAP     = 4;
    localparam int RST_CYC = 16;
    localparam int TMO     = 300;
    localparam logic [NUM_CH*STEP_W-1:0] INIT = {6'd10, 6'd2, 6'd0, 6'd0};

    typedef struct {
        logic       pulse;
        logic       busy;
        logic       rdy;
        logic       err;
        logic [5:0] ph;
        logic       chk_sel;
        logic [2:0] sel;
        logic       dir;
    } exp_t;

    logic              clk = 1'b0;
    logic              resetn;
    logic [2:0]        rd_ch;
    logic [STEP_W-1:0] rd_phase;
    logic              busy, locked, pll_lock, pll_reset, pll_psdir, pll_pspulse;
    logic [7:0]        relock_cnt;
    logic [2:0]        pll_pssel;

    pll_phase_ctrl_if #(.STEP_W(STEP_W)) rq ();

    pll_phase_ctrl #(
        .NUM_CH(NUM_CH), .STEP_W(STEP_W), .STEPS(STEPS), .INIT_PHASE(INIT),
        .PULSE_HI(HI), .PULSE_GAP(GAP), .RESET_CYCLES(RST_CYC), .LOCK_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .resetn(resetn), .req(rq), .rd_ch(rd_ch), .rd_phase(rd_phase),
        .busy(busy), .locked(locked), .relock_cnt(relock_cnt), .pll_lock(pll_lock),
        .pll_reset(pll_reset), .pll_pssel(pll_pssel), .pll_psdir(pll_psdir),
        .pll_pspulse(pll_pspulse)
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   miscompares = 0;
    int   mtbl [8];
    exp_t q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic p, input logic b, input logic r, input logic e,
                        input int ph, input logic cs, input int sel, input logic dir);
        exp_t x;
        x.pulse = p; x.busy = b; x.rdy = r; x.err = e; x.ph = 6'(ph);
        x.chk_sel = cs; x.sel = 3'(sel); x.dir = dir;
        q.push_back(x);
    endtask

    function automatic int wrap(input int v);
        return ((v % STEPS) + STEPS) % STEPS;
    endfunction

    // Compare process: one predicted cycle per negedge while a schedule is pending.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pspulse",   32'(pll_pspulse),  32'(e.pulse));
            chk("busy",      32'(busy),         32'(e.busy));
            chk("req_ready", 32'(rq.req_ready), 32'(e.rdy));
            chk("req_err",   32'(rq.req_err),   32'(e.err));
            chk("rd_phase",  32'(rd_phase),     32'(e.ph));
            chk("pll_reset", 32'(pll_reset),    32'd0);
            if (e.chk_sel) begin
                chk("pssel", 32'(pll_pssel), 32'(e.sel));
                chk("psdir", 32'(pll_psdir), 32'(e.dir));
            end
        end
    end

    task automatic wait_drain();
        int guard = 0;
        while (q.size() != 0 && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic issue(input int ch, input int ph);
        int cur, d, n, fin, pstep;
        logic dir, bad;
        wait_drain();
        bad = (ch >= NUM_CH) || (ph >= STEPS);
        cur = (ch < NUM_CH) ? mtbl[ch] : 0;
        d   = wrap(ph - cur);
        @(posedge clk); #2;
        rq.req_valid = 1'b1; rq.req_ch = 3'(ch); rq.req_phase = 6'(ph); rd_ch = 3'(ch);
        @(posedge clk); #2;
        rq.req_valid = 1'b0;
        if (bad) begin
            push(0, 0, 1, 1, cur, 0, 0, 0);
            push(0, 0, 1, 0, cur, 0, 0, 0);
        end else if (d == 0) begin
            push(0, 0, 0, 0, cur, 0, 0, 0);
            push(0, 0, 1, 0, cur, 0, 0, 0);
        end else begin
            dir = (d > STEPS / 2);
            n   = dir ? STEPS - d : d;
            push(0, 1, 0, 0, cur, 1, ch, dir);
            for (int i = 0; i < n; i++) begin
                pstep = wrap(dir ? cur - i : cur + i);
                for (int j = 0; j < HI + GAP; j++) push(j < HI, 1, 0, 0, pstep, 1, ch, dir);
            end
            fin = wrap(dir ? cur - n : cur + n);
            push(0, 1, 0, 0, fin, 1, ch, dir);
            push(0, 1, 0, 0, fin, 1, ch, dir);
            push(0, 0, 1, 0, fin, 0, 0, 0);
            mtbl[ch] = fin;
        end
    endtask

    task automatic lit_rd(input string name, input int ch, input int exp);
        wait_drain();
        @(posedge clk); #2;
        rd_ch = 3'(ch);
        @(negedge clk);
        chk(name, 32'(rd_phase), 32'(exp));
    endtask

    task automatic reset_mtbl();
        mtbl = '{0, 0, 2, 10, 0, 0, 0, 0};
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pll_reset"}, 32'(pll_reset),    32'd1);
        chk({tag, "_pspulse"},   32'(pll_pspulse),  32'd0);
        chk({tag, "_psdir"},     32'(pll_psdir),    32'd0);
        chk({tag, "_pssel"},     32'(pll_pssel),    32'd0);
        chk({tag, "_ready"},     32'(rq.req_ready), 32'd0);
        chk({tag, "_busy"},      32'(busy),         32'd1);
        chk({tag, "_locked"},    32'(locked),       32'd0);
        chk({tag, "_err"},       32'(rq.req_err),   32'd0);
        chk({tag, "_relock"},    32'(relock_cnt),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int guard;
        resetn = 1'b0; pll_lock = 1'b0; rd_ch = '0;
        rq.req_valid = 1'b0; rq.req_ch = '0; rq.req_phase = '0;
        reset_mtbl();

        // T1: reset values, 16-cycle PLL reset, lock at cycle 30 qualified by cycle 33
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_state("rst");
        @(posedge clk); #2;
        resetn = 1'b1;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            chk("t1_pll_reset", 32'(pll_reset),    32'(c < RST_CYC));
            chk("t1_locked",    32'(locked),       32'(c >= 33));
            chk("t1_ready",     32'(rq.req_ready), 32'(c >= 33));
            chk("t1_busy",      32'(busy),         32'(c < 33));
            if (c == 29) pll_lock = 1'b1;
        end

        // T2: plain advance
        issue(1, 5);
        lit_rd("t2_rd_ch1", 1, 5);
        // T3: retard across zero, then advance across the top
        issue(2, 60);
        lit_rd("t3_rd_ch2", 2, 60);
        issue(2, 3);
        lit_rd("t3_wrap_adv", 2, 3);
        // T4: half-turn tie advances; repeated target is a no-op
        issue(0, 32);
        lit_rd("t4_rd_ch0", 0, 32);
        issue(0, 32);
        // T5: out-of-range channels are rejected, table untouched
        issue(5, 10);
        issue(7, 0);
        lit_rd("t5_rd_ch5", 5, 0);
        lit_rd("t5_rd_ch2", 2, 3);

        // T6: one step, then lock lost long enough to force a PLL reset
        issue(3, 11);
        lit_rd("t6_step", 3, 11);
        @(posedge clk); #2;
        pll_lock = 1'b0;
        for (int c = 0; c <= 325; c++) begin
            @(negedge clk);
            chk("t6_locked",    32'(locked),     32'(c < 3));
            chk("t6_busy",      32'(busy),       32'(c >= 3));
            chk("t6_pll_reset", 32'(pll_reset),  32'(c >= 303 && c <= 318));
            chk("t6_relock",    32'(relock_cnt), 32'(c >= 303));
        end
        reset_mtbl();
        lit_rd("t6_tbl0", 0, 0);
        lit_rd("t6_tbl1", 1, 0);
        lit_rd("t6_tbl2", 2, 2);
        lit_rd("t6_tbl3", 3, 10);
        pll_lock = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!rq.req_ready && guard < 50);
        chk("t6_relocked", 32'(rq.req_ready), 32'd1);

        // Reset asserted during a retard pulse
        @(posedge clk); #2;
        rq.req_valid = 1'b1; rq.req_ch = 3'd0; rq.req_phase = 6'd40; rd_ch = 3'd0;
        @(posedge clk); #2;
        rq.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_pulse_hi", 32'(pll_pspulse), 32'd1);
        chk("mid_psdir",    32'(pll_psdir),   32'd1);
        resetn = 1'b0;
        @(negedge clk);
        chk_reset_state("mid");
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
